// File: rtl/axi4_mem_responder.sv
// axi4_mem_responder
// AXI4 slave backed by on-chip memory of 2^MEM_AW 512-bit words. Stands in
// for a DDR channel in simulation and bring-up. Write and read channels run
// independent FSMs, each with at most one burst in flight.
//
// Ports
//   clk_main_a0, pipe_rst_n    clock, async active-low reset
//   aw*/w*/b*                  write address, data and response channels
//   ar*/r*                     read address and data channels
//
// All bursts are INCR with full 64-byte beats; word index = addr[MEM_AW+5:6],
// incrementing per beat and wrapping modulo the memory depth.
//
// state  | meaning
// W_IDLE | awready high, waiting for an AW handshake
// W_DATA | wready high, accepting beats until beat == len
// W_RESP | bvalid high until bready
// R_IDLE | arready high, waiting for an AR handshake
// R_WAIT | counting down the read latency
// R_DATA | rvalid high, one beat per rready handshake
module axi4_mem_responder #(
   parameter int MEM_AW = 10,
   parameter int RD_LAT = 4,
   parameter int ID_W   = 16
) (
   input  logic              clk_main_a0,
   input  logic              pipe_rst_n,
   input  logic [ID_W-1:0]   awid,
   input  logic [63:0]       awaddr,
   input  logic [7:0]        awlen,
   input  logic              awvalid,
   output logic              awready,
   input  logic [511:0]      wdata,
   input  logic [63:0]       wstrb,
   input  logic              wlast,
   input  logic              wvalid,
   output logic              wready,
   output logic [ID_W-1:0]   bid,
   output logic [1:0]        bresp,
   output logic              bvalid,
   input  logic              bready,
   input  logic [ID_W-1:0]   arid,
   input  logic [63:0]       araddr,
   input  logic [7:0]        arlen,
   input  logic              arvalid,
   output logic              arready,
   output logic [ID_W-1:0]   rid,
   output logic [511:0]      rdata,
   output logic [1:0]        rresp,
   output logic              rlast,
   output logic              rvalid,
   input  logic              rready
);

   localparam int         DEPTH   = 1 << MEM_AW;
   localparam logic [7:0] WAIT_LD = 8'(RD_LAT - 1);

   typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
   typedef enum logic [1:0] {R_IDLE, R_WAIT, R_DATA} r_state_t;

   logic [511:0] mem_q [DEPTH];

   w_state_t            w_state_q;
   logic                awready_q, wready_q, bvalid_q, w_err_q;
   logic [ID_W-1:0]     w_id_q, bid_q;
   logic [1:0]          bresp_q;
   logic [MEM_AW-1:0]   w_idx_q;
   logic [7:0]          w_beat_q, w_len_q;

   r_state_t            r_state_q;
   logic                arready_q, rvalid_q, rlast_q;
   logic [ID_W-1:0]     rid_q;
   logic [511:0]        rdata_q;
   logic [MEM_AW-1:0]   r_idx_q;
   logic [7:0]          r_beat_q, r_len_q, r_cnt_q;

   logic                w_hs, w_last_beat, w_err_d;
   logic [MEM_AW-1:0]   aw_idx, ar_idx, r_idx_d;
   logic                unused_addr;

   assign w_hs        = wvalid && wready_q;
   assign w_last_beat = (w_beat_q == w_len_q);
   // wlast is only a cross-check; the beat count alone ends the burst.
   assign w_err_d     = w_err_q | (wlast != w_last_beat);
   assign aw_idx      = awaddr[MEM_AW+5:6];
   assign ar_idx      = araddr[MEM_AW+5:6];
   assign r_idx_d     = r_idx_q + MEM_AW'(1);
   assign unused_addr = ^{awaddr[63:MEM_AW+6], awaddr[5:0], araddr[63:MEM_AW+6], araddr[5:0]};

   // Memory is deliberately outside the reset domain: contents survive reset.
   always_ff @(posedge clk_main_a0) begin
      if (w_hs) begin
         for (int b = 0; b < 64; b++) begin
            if (wstrb[b]) mem_q[w_idx_q][b*8 +: 8] <= wdata[b*8 +: 8];
         end
      end
   end

   always_ff @(posedge clk_main_a0 or negedge pipe_rst_n) begin
      if (!pipe_rst_n) begin
         w_state_q <= W_IDLE;
         awready_q <= 1'b0;
         wready_q  <= 1'b0;
         bvalid_q  <= 1'b0;
         bid_q     <= '0;
         bresp_q   <= 2'b00;
         w_id_q    <= '0;
         w_idx_q   <= '0;
         w_beat_q  <= 8'd0;
         w_len_q   <= 8'd0;
         w_err_q   <= 1'b0;
      end else begin
         case (w_state_q)
            W_IDLE: begin
               awready_q <= 1'b1;
               if (awvalid && awready_q) begin
                  awready_q <= 1'b0;
                  wready_q  <= 1'b1;
                  w_id_q    <= awid;
                  w_idx_q   <= aw_idx;
                  w_len_q   <= awlen;
                  w_beat_q  <= 8'd0;
                  w_err_q   <= 1'b0;
                  w_state_q <= W_DATA;
               end
            end
            W_DATA: begin
               if (w_hs) begin
                  w_idx_q  <= w_idx_q + MEM_AW'(1);
                  w_beat_q <= w_beat_q + 8'd1;
                  w_err_q  <= w_err_d;
                  if (w_last_beat) begin
                     wready_q  <= 1'b0;
                     bvalid_q  <= 1'b1;
                     bid_q     <= w_id_q;
                     bresp_q   <= w_err_d ? 2'b10 : 2'b00;
                     w_state_q <= W_RESP;
                  end
               end
            end
            W_RESP: begin
               if (bready) begin
                  bvalid_q  <= 1'b0;
                  awready_q <= 1'b1;
                  w_state_q <= W_IDLE;
               end
            end
            default: w_state_q <= W_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk_main_a0 or negedge pipe_rst_n) begin
      if (!pipe_rst_n) begin
         r_state_q <= R_IDLE;
         arready_q <= 1'b0;
         rvalid_q  <= 1'b0;
         rlast_q   <= 1'b0;
         rid_q     <= '0;
         rdata_q   <= '0;
         r_idx_q   <= '0;
         r_beat_q  <= 8'd0;
         r_len_q   <= 8'd0;
         r_cnt_q   <= 8'd0;
      end else begin
         case (r_state_q)
            R_IDLE: begin
               arready_q <= 1'b1;
               if (arvalid && arready_q) begin
                  arready_q <= 1'b0;
                  rid_q     <= arid;
                  r_idx_q   <= ar_idx;
                  r_len_q   <= arlen;
                  r_beat_q  <= 8'd0;
                  r_cnt_q   <= WAIT_LD;
                  if (RD_LAT == 1) begin
                     rvalid_q  <= 1'b1;
                     rdata_q   <= mem_q[ar_idx];
                     rlast_q   <= (arlen == 8'd0);
                     r_state_q <= R_DATA;
                  end else begin
                     r_state_q <= R_WAIT;
                  end
               end
            end
            R_WAIT: begin
               // Terminal count 1: the load below makes rvalid visible on the next cycle.
               if (r_cnt_q == 8'd1) begin
                  rvalid_q  <= 1'b1;
                  rdata_q   <= mem_q[r_idx_q];
                  rlast_q   <= (r_len_q == 8'd0);
                  r_state_q <= R_DATA;
               end else begin
                  r_cnt_q <= r_cnt_q - 8'd1;
               end
            end
            R_DATA: begin
               if (rready) begin
                  if (rlast_q) begin
                     rvalid_q  <= 1'b0;
                     rlast_q   <= 1'b0;
                     arready_q <= 1'b1;
                     r_state_q <= R_IDLE;
                  end else begin
                     r_idx_q  <= r_idx_d;
                     r_beat_q <= r_beat_q + 8'd1;
                     rdata_q  <= mem_q[r_idx_d];
                     rlast_q  <= ((r_beat_q + 8'd1) == r_len_q);
                  end
               end
            end
            default: r_state_q <= R_IDLE;
         endcase
      end
   end

   assign awready = awready_q;
   assign wready  = wready_q;
   assign bid     = bid_q;
   assign bresp   = bresp_q;
   assign bvalid  = bvalid_q;
   assign arready = arready_q;
   assign rid     = rid_q;
   assign rdata   = rdata_q;
   assign rresp   = 2'b00;
   assign rlast   = rlast_q;
   assign rvalid  = rvalid_q;

endmodule

// File: tb/tb_axi4_mem_responder.sv
module tb_axi4_mem_responder;

   localparam int MEM_AW = 10;
   localparam int RD_LAT = 4;
   localparam int ID_W   = 16;

   logic            clk_main_a0 = 1'b0;
   logic            pipe_rst_n;
   logic [ID_W-1:0] awid, arid, bid, rid;
   logic [63:0]     awaddr, araddr, wstrb;
   logic [7:0]      awlen, arlen;
   logic            awvalid, awready, wlast, wvalid, wready, bvalid, bready;
   logic            arvalid, arready, rlast, rvalid, rready;
   logic [511:0]    wdata, rdata;
   logic [1:0]      bresp, rresp;

   axi4_mem_responder #(.MEM_AW(MEM_AW), .RD_LAT(RD_LAT), .ID_W(ID_W)) dut (
      .clk_main_a0(clk_main_a0), .pipe_rst_n(pipe_rst_n),
      .awid(awid), .awaddr(awaddr), .awlen(awlen), .awvalid(awvalid), .awready(awready),
      .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
      .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
      .arid(arid), .araddr(araddr), .arlen(arlen), .arvalid(arvalid), .arready(arready),
      .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
   );

   always #5 clk_main_a0 = ~clk_main_a0;

   int              checks = 0;
   int              errors = 0;
   logic [511:0]    wd [8];
   logic [63:0]     ws [8];
   logic [511:0]    rd [8];
   logic            rl [8];
   logic [ID_W-1:0] got_bid, got_rid;
   logic [1:0]      got_bresp;
   int              lat, span;

   task automatic write_burst(input logic [ID_W-1:0] id, input logic [63:0] addr,
                              input logic [7:0] len, input int lastbeat);
      int n;
      awid = id; awaddr = addr; awlen = len; awvalid = 1'b1;
      n = 0;
      while (!awready && n < 50) begin @(posedge clk_main_a0); #1; n++; end
      checks++;
      if (awready !== 1'b1) begin errors++; $display("FAIL aw_wait got awready=%b exp=1", awready); end
      @(posedge clk_main_a0); #1;
      awvalid = 1'b0;
      for (int i = 0; i <= int'(len); i++) begin
         wdata = wd[i]; wstrb = ws[i]; wlast = (i == lastbeat); wvalid = 1'b1;
         n = 0;
         while (!wready && n < 50) begin @(posedge clk_main_a0); #1; n++; end
         checks++;
         if (wready !== 1'b1) begin errors++; $display("FAIL w_wait beat=%0d got wready=%b exp=1", i, wready); end
         @(posedge clk_main_a0); #1;
      end
      wvalid = 1'b0; wlast = 1'b0; bready = 1'b1;
      n = 0;
      while (!bvalid && n < 50) begin @(posedge clk_main_a0); #1; n++; end
      checks++;
      if (bvalid !== 1'b1) begin errors++; $display("FAIL b_wait got bvalid=%b exp=1", bvalid); end
      got_bid = bid; got_bresp = bresp;
      @(posedge clk_main_a0); #1;
      bready = 1'b0;
   endtask

   task automatic read_burst(input logic [ID_W-1:0] id, input logic [63:0] addr,
                             input logic [7:0] len, input bit stall);
      int n, beat, cyc;
      bit have_hold;
      logic [511:0] hd;
      logic hl;
      logic [ID_W-1:0] hi;
      arid = id; araddr = addr; arlen = len; arvalid = 1'b1;
      n = 0;
      while (!arready && n < 50) begin @(posedge clk_main_a0); #1; n++; end
      checks++;
      if (arready !== 1'b1) begin errors++; $display("FAIL ar_wait got arready=%b exp=1", arready); end
      @(posedge clk_main_a0); #1;
      arvalid = 1'b0;
      lat = 1;
      while (!rvalid && lat < 300) begin @(posedge clk_main_a0); #1; lat++; end
      checks++;
      if (rvalid !== 1'b1) begin errors++; $display("FAIL r_wait got rvalid=%b exp=1", rvalid); end
      checks++;
      if (arready !== 1'b0) begin errors++; $display("FAIL ar_backpressure got arready=%b exp=0", arready); end
      got_rid = rid;
      beat = 0; cyc = 0; have_hold = 0;
      while (beat <= int'(len) && cyc < 200) begin
         if (!stall) rready = 1'b1;
         else if (cyc % 4 == 1) rready = 1'b0;
         else rready = 1'($urandom_range(0, 1));
         if (rvalid) begin
            if (have_hold) begin
               checks++;
               if (rdata !== hd || rlast !== hl || rid !== hi) begin
                  errors++;
                  $display("FAIL stall_stable beat=%0d got rlast=%b rid=%h rdata=%h exp rlast=%b rid=%h rdata=%h",
                           beat, rlast, rid, rdata, hl, hi, hd);
               end
            end
            if (rready) begin
               rd[beat] = rdata; rl[beat] = rlast; beat++; have_hold = 0;
            end else begin
               hd = rdata; hl = rlast; hi = rid; have_hold = 1;
            end
         end
         @(posedge clk_main_a0); #1;
         cyc++;
      end
      rready = 1'b0;
      span = cyc;
      checks++;
      if (beat <= int'(len)) begin errors++; $display("FAIL r_beats got=%0d exp=%0d", beat, int'(len) + 1); end
   endtask

   task automatic test_reset;
      pipe_rst_n = 1'b0;
      awid = '0; awaddr = '0; awlen = '0; awvalid = 0; wdata = '0; wstrb = '0; wlast = 0; wvalid = 0;
      bready = 0; arid = '0; araddr = '0; arlen = '0; arvalid = 0; rready = 0;
      repeat (3) @(posedge clk_main_a0);
      #1;
      checks++;
      if ({awready, wready, bvalid, arready, rvalid, rlast} !== 6'b0) begin
         errors++;
         $display("FAIL reset_ctrl got aw/w/b/ar/r/rlast=%b exp=000000", {awready, wready, bvalid, arready, rvalid, rlast});
      end
      checks++;
      if (rdata !== '0 || bid !== '0 || rid !== '0 || bresp !== 2'b00 || rresp !== 2'b00) begin
         errors++;
         $display("FAIL reset_data got bid=%h rid=%h bresp=%b rdata_nonzero=%b exp all 0", bid, rid, bresp, |rdata);
      end
      pipe_rst_n = 1'b1;
      @(posedge clk_main_a0); #1;
      checks++;
      if (awready !== 1'b1 || arready !== 1'b1) begin
         errors++; $display("FAIL reset_release got awready=%b arready=%b exp 1 1", awready, arready);
      end
   endtask

   task automatic test_single;
      wd[0] = {64{8'hA5}}; ws[0] = '1;
      write_burst(16'h1234, 64'h40, 8'd0, 0);
      checks++;
      if (got_bresp !== 2'b00 || got_bid !== 16'h1234) begin
         errors++; $display("FAIL single_b got bid=%h bresp=%b exp 1234 00", got_bid, got_bresp);
      end
      read_burst(16'h0055, 64'h40, 8'd0, 0);
      checks++;
      if (lat != RD_LAT) begin errors++; $display("FAIL single_latency got=%0d exp=%0d", lat, RD_LAT); end
      checks++;
      if (rd[0] !== {64{8'hA5}} || rl[0] !== 1'b1 || got_rid !== 16'h0055) begin
         errors++; $display("FAIL single_r got rid=%h rlast=%b rdata=%h exp rid=0055 rlast=1 all a5", got_rid, rl[0], rd[0]);
      end
   endtask

   task automatic test_burst;
      for (int i = 0; i < 4; i++) begin wd[i] = 512'(i + 1); ws[i] = '1; end
      write_burst(16'h0007, 64'h0, 8'd3, 3);
      checks++;
      if (got_bresp !== 2'b00 || got_bid !== 16'h0007) begin
         errors++; $display("FAIL burst_b got bid=%h bresp=%b exp 0007 00", got_bid, got_bresp);
      end
      read_burst(16'h00AB, 64'h0, 8'd3, 0);
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (rd[i] !== 512'(i + 1) || rl[i] !== (i == 3)) begin
            errors++; $display("FAIL burst_beat%0d got rlast=%b rdata=%h exp rlast=%b rdata=%0d", i, rl[i], rd[i], i == 3, i + 1);
         end
      end
      checks++;
      if (span != 4 || got_rid !== 16'h00AB) begin
         errors++; $display("FAIL burst_b2b got cycles=%0d rid=%h exp 4 00ab", span, got_rid);
      end
   endtask

   task automatic test_strobe;
      logic [511:0] exp;
      wd[0] = '1; ws[0] = '1;
      write_burst(16'h0001, 64'h100, 8'd0, 0);
      wd[0] = '0; ws[0] = 64'h1;
      write_burst(16'h0002, 64'h100, 8'd0, 0);
      read_burst(16'h0003, 64'h100, 8'd0, 0);
      exp = '1; exp[7:0] = 8'h00;
      checks++;
      if (rd[0] !== exp) begin errors++; $display("FAIL strobe got=%h exp=%h", rd[0], exp); end
   endtask

   task automatic test_wrap;
      wd[0] = 512'h111; wd[1] = 512'h222; ws[0] = '1; ws[1] = '1;
      write_burst(16'h0003, 64'hFFC0, 8'd1, 1);
      checks++;
      if (got_bresp !== 2'b00) begin errors++; $display("FAIL wrap_b got bresp=%b exp=00", got_bresp); end
      read_burst(16'h0004, 64'h0, 8'd0, 0);
      checks++;
      if (rd[0] !== 512'h222) begin errors++; $display("FAIL wrap_word0 got=%h exp=222", rd[0]); end
      read_burst(16'h0005, 64'hABCD_0000_0000_FFC0, 8'd0, 0);
      checks++;
      if (rd[0] !== 512'h111) begin errors++; $display("FAIL wrap_word1023 got=%h exp=111", rd[0]); end
   endtask

   task automatic test_proto_err;
      wd[0] = 512'hE0; wd[1] = 512'hE1; ws[0] = '1; ws[1] = '1;
      write_burst(16'h0004, 64'h200, 8'd1, 0);
      checks++;
      if (got_bresp !== 2'b10 || got_bid !== 16'h0004) begin
         errors++; $display("FAIL early_wlast_b got bid=%h bresp=%b exp 0004 10", got_bid, got_bresp);
      end
      read_burst(16'h0006, 64'h200, 8'd1, 0);
      checks++;
      if (rd[0] !== 512'hE0 || rd[1] !== 512'hE1) begin
         errors++; $display("FAIL early_wlast_data got %h %h exp e0 e1", rd[0], rd[1]);
      end
      wd[0] = 512'h99;
      write_burst(16'h0005, 64'h240, 8'd0, -1);
      checks++;
      if (got_bresp !== 2'b10) begin errors++; $display("FAIL missing_wlast_b got bresp=%b exp=10", got_bresp); end
   endtask

   task automatic test_stall;
      for (int i = 0; i < 8; i++) begin wd[i] = 512'h1000 + 512'(i); ws[i] = '1; end
      write_burst(16'h0006, 64'h400, 8'd7, 7);
      read_burst(16'h0008, 64'h400, 8'd7, 1);
      for (int i = 0; i < 8; i++) begin
         checks++;
         if (rd[i] !== 512'h1000 + 512'(i) || rl[i] !== (i == 7)) begin
            errors++; $display("FAIL stall_beat%0d got rlast=%b rdata=%h exp rlast=%b rdata=%h", i, rl[i], rd[i], i == 7, 512'h1000 + 512'(i));
         end
      end
   endtask

   task automatic test_reset_mid;
      int n;
      logic [511:0] exp;
      arid = 16'h0009; araddr = 64'h400; arlen = 8'd7; arvalid = 1'b1;
      n = 0;
      while (!arready && n < 50) begin @(posedge clk_main_a0); #1; n++; end
      @(posedge clk_main_a0); #1;
      arvalid = 1'b0; rready = 1'b1;
      n = 0;
      while (!rvalid && n < 50) begin @(posedge clk_main_a0); #1; n++; end
      checks++;
      if (rvalid !== 1'b1) begin errors++; $display("FAIL mid_wait got rvalid=%b exp=1", rvalid); end
      repeat (2) begin @(posedge clk_main_a0); #1; end
      pipe_rst_n = 1'b0;
      #1;
      checks++;
      if (rvalid !== 1'b0 || rlast !== 1'b0 || arready !== 1'b0) begin
         errors++; $display("FAIL mid_reset got rvalid=%b rlast=%b arready=%b exp 0 0 0", rvalid, rlast, arready);
      end
      #2;
      rready = 1'b0;
      pipe_rst_n = 1'b1;
      @(posedge clk_main_a0); #1;
      checks++;
      if (arready !== 1'b1 || rvalid !== 1'b0) begin
         errors++; $display("FAIL mid_release got arready=%b rvalid=%b exp 1 0", arready, rvalid);
      end
      read_burst(16'h000A, 64'h100, 8'd0, 0);
      exp = '1; exp[7:0] = 8'h00;
      checks++;
      if (rd[0] !== exp) begin errors++; $display("FAIL mid_retained got=%h exp=%h", rd[0], exp); end
      read_burst(16'h000B, 64'h400, 8'd7, 0);
      checks++;
      if (rd[7] !== 512'h1007 || rl[7] !== 1'b1) begin
         errors++; $display("FAIL mid_reread got rlast=%b rdata=%h exp 1 1007", rl[7], rd[7]);
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_burst();
      test_strobe();
      test_wrap();
      test_proto_err();
      test_stall();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog got time=%0t exp finish before", $time);
      $fatal(1, "watchdog expired");
   end

endmodule
